// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; bytes go out LSB first, back-to-back
// with no idle gap while the FIFO holds data.
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [7:0]                       tx_data_i,
  input  logic                             tx_valid_i,
  output logic                             tx_ready_o,
  output logic                             tx_serial_o,
  output logic                             tx_active_o,
  output logic                             tx_done_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BaudW-1:0] BaudDone = BaudW'(CLKS_PER_BIT - 2);
  localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  state_e           state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             serial_q, active_q, done_q, ready_q;
  logic             push, pop, baud_last;

  assign baud_last = (baud_q == BaudLast);
  assign push      = tx_valid_i & ready_q;
  // The FSM takes a new byte either from idle or on the last stop-bit cycle.
  assign pop       = (count_q != '0) &
                     ((state_q == StIdle) | ((state_q == StStop) & baud_last));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != CntFull);
      // Registered one cycle early so the pulse lands on the final stop-bit cycle.
      done_q  <= (state_q == StStop) && (baud_q == BaudDone);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        shift_q  <= mem_q[rd_ptr_q];
      end
      baud_q <= baud_last ? '0 : baud_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          baud_q <= '0;
          if (pop) begin
            state_q  <= StStart;
            serial_q <= 1'b0;
            active_q <= 1'b1;
          end
        end
        StStart: begin
          if (baud_last) begin
            state_q   <= StData;
            bit_idx_q <= '0;
            serial_q  <= shift_q[0];
          end
        end
        StData: begin
          if (baud_last) begin
            if (bit_idx_q == 3'd7) begin
              state_q  <= StStop;
              serial_q <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              serial_q  <= shift_q[1];
              shift_q   <= shift_q >> 1;
            end
          end
        end
        StStop: begin
          if (baud_last) begin
            if (pop) begin
              state_q  <= StStart;
              serial_q <= 1'b0;
            end else begin
              state_q  <= StIdle;
              active_q <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_ready_o   = ready_q;
  assign tx_serial_o  = serial_q;
  assign tx_active_o  = active_q;
  assign tx_done_o    = done_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a full-rate instance for exact waveform timing and
// a small fast instance (4 clocks/bit, depth 4) with a receiver model on its line.
module tb_uart_tx_fifo;

  localparam int unsigned BigCpb   = 217;
  localparam int unsigned BigDepth = 8;
  localparam int unsigned SmCpb    = 4;
  localparam int unsigned SmDepth  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] b_data = '0;
  logic       b_valid = 1'b0;
  logic       b_ready, b_serial, b_active, b_done;
  logic [3:0] b_count;

  logic [7:0] s_data = '0;
  logic       s_valid = 1'b0;
  logic       s_ready, s_serial, s_active, s_done;
  logic [2:0] s_count;

  int vectors = 0;
  int miscompares = 0;

  byte unsigned rx_q[$];
  longint       rx_t[$];
  int           rx_frame_err = 0;
  int           s_done_cnt = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(BigCpb), .FIFO_DEPTH(BigDepth)) dut_big (
    .clk_i(clk), .rst_i(rst), .tx_data_i(b_data), .tx_valid_i(b_valid),
    .tx_ready_o(b_ready), .tx_serial_o(b_serial), .tx_active_o(b_active),
    .tx_done_o(b_done), .fifo_count_o(b_count)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(SmCpb), .FIFO_DEPTH(SmDepth)) dut_small (
    .clk_i(clk), .rst_i(rst), .tx_data_i(s_data), .tx_valid_i(s_valid),
    .tx_ready_o(s_ready), .tx_serial_o(s_serial), .tx_active_o(s_active),
    .tx_done_o(s_done), .fifo_count_o(s_count)
  );

  always @(negedge clk) if (s_done === 1'b1) s_done_cnt++;

  // Receiver on the small line: samples mid-bit on falling clock edges.
  initial begin : rx_model
    logic [7:0] sh;
    logic       ok;
    longint     t0;
    forever begin
      @(negedge s_serial);
      t0 = $time;
      repeat (3) @(negedge clk);
      ok = (s_serial === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (SmCpb) @(negedge clk);
        sh[i] = s_serial;
      end
      repeat (SmCpb) @(negedge clk);
      if (ok && s_serial === 1'b1) begin
        rx_q.push_back(sh);
        rx_t.push_back(t0);
      end else begin
        rx_frame_err++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic push_small(input logic [7:0] d, output int waited);
    logic r;
    s_data  = d;
    s_valid = 1'b1;
    waited  = 0;
    do begin
      r = s_ready;
      @(posedge clk); #1;
      waited++;
    end while (!r && waited < 500);
    s_valid = 1'b0;
    if (!r) begin
      vectors++; miscompares++;
      $display("FAIL push_timeout: ready=%0b after %0d cycles, required 1", r, waited);
    end
  endtask

  task automatic wait_small_idle();
    int n = 0;
    while (!(s_active === 1'b0 && s_count === 3'd0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      vectors++; miscompares++;
      $display("FAIL idle_timeout: active=%0b count=%0d, required 0/0", s_active, s_count);
    end
    repeat (4) @(posedge clk);
    #1;
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    int sz;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    sz = rx_q.size();
    vectors++;
    if (sz !== n) begin
      miscompares++;
      $display("FAIL rx_count: received %0d bytes, required %0d", sz, n);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({b_serial, b_ready, b_active, b_done, b_count} !== 8'hC0) begin
      miscompares++;
      $display("FAIL reset_big: got %b required 11000000",
               {b_serial, b_ready, b_active, b_done, b_count});
    end
    vectors++;
    if ({s_serial, s_ready, s_active, s_done, s_count} !== 7'h60) begin
      miscompares++;
      $display("FAIL reset_small: got %b required 1100000",
               {s_serial, s_ready, s_active, s_done, s_count});
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({b_serial, b_ready, b_active, b_done, b_count} !== 8'hC0) begin
      miscompares++;
      $display("FAIL post_reset_big: got %b required 11000000",
               {b_serial, b_ready, b_active, b_done, b_count});
    end
    vectors++;
    if ({s_serial, s_ready, s_active, s_done, s_count} !== 7'h60) begin
      miscompares++;
      $display("FAIL post_reset_small: got %b required 1100000",
               {s_serial, s_ready, s_active, s_done, s_count});
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] d = 8'hA5;
    logic       e;
    int line_err = 0, first_bad = -1, act_cyc = 0, done_cnt = 0, done_k = -1;
    b_data  = d;
    b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    vectors++;
    if (b_count !== 4'd1 || b_serial !== 1'b1) begin
      miscompares++;
      $display("FAIL single_push: count=%0d line=%0b required 1/1", b_count, b_serial);
    end
    for (int k = 0; k < 2200; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        vectors++;
        if (b_count !== 4'd0) begin
          miscompares++;
          $display("FAIL single_pop_count: got %0d required 0", b_count);
        end
      end
      if (k < 217) e = 1'b0;
      else if (k < 1953) e = d[(k - 217) / 217];
      else e = 1'b1;
      if (b_serial !== e) begin
        line_err++;
        if (first_bad < 0) first_bad = k;
      end
      if (b_active === 1'b1) act_cyc++;
      if (b_done === 1'b1) begin
        done_cnt++;
        done_k = k;
      end
    end
    vectors++;
    if (line_err !== 0) begin
      miscompares++;
      $display("FAIL single_line: %0d bad cycles (first at %0d), required 0", line_err, first_bad);
    end
    vectors++;
    if (act_cyc !== 2170) begin
      miscompares++;
      $display("FAIL single_active: %0d cycles, required 2170", act_cyc);
    end
    vectors++;
    if (done_cnt !== 1 || done_k !== 2169) begin
      miscompares++;
      $display("FAIL single_done: %0d pulses last at %0d, required 1 at 2169", done_cnt, done_k);
    end
  endtask

  task automatic test_backpressure();
    byte unsigned bp[6] = '{8'h5A, 8'hC3, 8'h01, 8'h80, 8'h7E, 8'hF0};
    int exp_edge[6] = '{1, 2, 3, 4, 5, 43};
    int w, edge_n = 0;
    wait_small_idle();
    for (int i = 0; i < 6; i++) begin
      push_small(bp[i], w);
      edge_n += w;
      vectors++;
      if (edge_n !== exp_edge[i]) begin
        miscompares++;
        $display("FAIL bp_accept_edge[%0d]: got %0d required %0d", i, edge_n, exp_edge[i]);
      end
      if (i == 4) begin
        vectors++;
        if (s_ready !== 1'b0 || s_count !== 3'd4) begin
          miscompares++;
          $display("FAIL bp_full: ready=%0b count=%0d required 0/4", s_ready, s_count);
        end
      end
    end
    wait_rx(6, 400);
    if (rx_q.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (rx_q[i] !== bp[i]) begin
          miscompares++;
          $display("FAIL bp_data[%0d]: got %02h required %02h", i, rx_q[i], bp[i]);
        end
      end
      for (int i = 1; i < 6; i++) begin
        vectors++;
        if (rx_t[i] - rx_t[i-1] !== 64'd400) begin
          miscompares++;
          $display("FAIL bp_pitch[%0d]: got %0d time units required 400", i, rx_t[i] - rx_t[i-1]);
        end
      end
    end
  endtask

  task automatic test_loopback();
    byte unsigned lb[3] = '{8'h00, 8'hFF, 8'h3C};
    int w;
    wait_small_idle();
    rx_frame_err = 0;
    for (int i = 0; i < 3; i++) push_small(lb[i], w);
    wait_rx(3, 300);
    if (rx_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rx_q[i] !== lb[i]) begin
          miscompares++;
          $display("FAIL loop_data[%0d]: got %02h required %02h", i, rx_q[i], lb[i]);
        end
      end
    end
    vectors++;
    if (rx_frame_err !== 0) begin
      miscompares++;
      $display("FAIL loop_framing: %0d framing errors, required 0", rx_frame_err);
    end
  endtask

  task automatic test_simul_push_pop();
    byte unsigned sp[3] = '{8'hA1, 8'hB2, 8'hC3};
    int w;
    wait_small_idle();
    push_small(sp[0], w);
    push_small(sp[1], w);
    vectors++;
    if (s_count !== 3'd1) begin
      miscompares++;
      $display("FAIL sim_idle_count: got %0d required 1", s_count);
    end
    repeat (39) @(posedge clk);
    #1;
    vectors++;
    if (s_done !== 1'b1 || s_count !== 3'd1 || s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL sim_last_stop: done=%0b count=%0d ready=%0b required 1/1/1",
               s_done, s_count, s_ready);
    end
    s_data  = sp[2];
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    vectors++;
    if (s_count !== 3'd1 || s_serial !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_stop_count: count=%0d line=%0b required 1/0", s_count, s_serial);
    end
    wait_rx(3, 300);
    repeat (60) @(posedge clk);
    #1;
    vectors++;
    if (rx_q.size() !== 3 || s_count !== 3'd0) begin
      miscompares++;
      $display("FAIL sim_total: %0d bytes count=%0d required 3/0", rx_q.size(), s_count);
    end
    if (rx_q.size() >= 3) begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (rx_q[i] !== sp[i]) begin
          miscompares++;
          $display("FAIL sim_data[%0d]: got %02h required %02h", i, rx_q[i], sp[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int w, d0;
    wait_small_idle();
    push_small(8'hF7, w);
    push_small(8'h11, w);
    repeat (17) @(posedge clk);
    #1;
    vectors++;
    if (s_serial !== 1'b0 || s_count !== 3'd1) begin
      miscompares++;
      $display("FAIL rm_bit3: line=%0b count=%0d required 0/1", s_serial, s_count);
    end
    d0 = s_done_cnt;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({s_serial, s_count, s_active} !== 5'b10000) begin
      miscompares++;
      $display("FAIL rm_immediate: line=%0b count=%0d active=%0b required 1/0/0",
               s_serial, s_count, s_active);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    vectors++;
    if (s_done_cnt !== d0 || s_serial !== 1'b1 || s_count !== 3'd0) begin
      miscompares++;
      $display("FAIL rm_after: done_pulses=%0d line=%0b count=%0d required %0d/1/0",
               s_done_cnt - d0, s_serial, s_count, 0);
    end
    rx_q.delete();
    rx_t.delete();
    push_small(8'h96, w);
    wait_rx(1, 100);
    repeat (5) @(posedge clk);
    #1;
    if (rx_q.size() >= 1) begin
      vectors++;
      if (rx_q[0] !== 8'h96) begin
        miscompares++;
        $display("FAIL rm_resume_data: got %02h required 96", rx_q[0]);
      end
    end
    vectors++;
    if (s_done_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL rm_resume_done: got %0d pulses required 1", s_done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    int w;
    wait_small_idle();
    for (int i = 0; i < 3 * SmDepth + 1; i++) push_small(8'(8'h10 + i), w);
    wait_rx(3 * SmDepth + 1, 400);
    if (rx_q.size() >= 3 * SmDepth + 1) begin
      for (int i = 0; i < 3 * SmDepth + 1; i++) begin
        vectors++;
        if (rx_q[i] !== 8'(8'h10 + i)) begin
          miscompares++;
          $display("FAIL wrap_data[%0d]: got %02h required %02h", i, rx_q[i], 8'(8'h10 + i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_backpressure();
    test_loopback();
    test_simul_push_pop();
    test_reset_midframe();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
